cla_addsub_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 15-bit combinational CLA add/sub unit. Operand width is split into lookahead groups, one group per pipeline stage; the carry ripples stage-to-stage through registers. Valid/ready streaming on both sides lets datapath blocks feed it back-to-back with backpressure. Produces sum, raw carry-out and two's-complement overflow per transaction.

---
 rtl/cla_pkg.sv | 34 +++
 rtl/cla_group.sv | 48 ++++
 rtl/cla_addsub_pipe.sv | 151 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// ============================================================================
// Module : cla_pkg
// Brief  : Shared constants and helpers for the pipelined CLA add/sub unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int calc_nstage(input int width, input int group);
        return (width + group - 1) / group;
    endfunction

    // The last group takes whatever bits remain, so it may be narrower.
    function automatic int group_width(input int width, input int group, input int k);
        int lo;
        lo = k * group;
        return ((width - lo) < group) ? (width - lo) : group;
    endfunction

    function automatic logic sat_max_bit(input int idx, input int width);
        return (idx == width - 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic sat_min_bit(input int idx, input int width);
        return (idx == width - 1) ? 1'b1 : 1'b0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_group.sv
// ============================================================================
// Module : cla_group
// Brief  : Combinational carry-lookahead group; every carry is a flat
//          sum-of-products of generate/propagate terms and carry-in.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_group #(
    parameter int GW = 5
) (
    input  logic [GW-1:0] a,
    input  logic [GW-1:0] b,
    input  logic          cin,
    output logic [GW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    logic [GW-1:0] g;
    logic [GW-1:0] p;
    logic [GW:0]   c;
    logic          pp;

    assign g = a & b;
    assign p = a ^ b;

    // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1:0]cin, built term by term.
    always_comb begin
        c  = '0;
        pp = 1'b0;
        for (int i = 0; i <= GW; i++) begin
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pp);
                pp   = pp & p[j];
            end
            c[i] = c[i] | (pp & cin);
        end
    end

    assign sum   = p ^ c[GW-1:0];
    assign cout  = c[GW];
    assign c_msb = c[GW-1];

endmodule

`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
// ============================================================================
// Module : cla_addsub_pipe
// Brief  : Pipelined carry-lookahead adder/subtractor, one lookahead group per
//          stage, valid/ready on both sides. Define CLA_PIPE_SAT_EN to clamp
//          out_sum on signed overflow.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int GROUP = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSTAGE = calc_nstage(WIDTH, GROUP);
    localparam int LAST   = NSTAGE - 1;

    logic [WIDTH-1:0] a_q     [NSTAGE];
    logic [WIDTH-1:0] b_q     [NSTAGE];
    logic [WIDTH-1:0] sum_q   [NSTAGE];
    logic             cout_q  [NSTAGE];
    logic             valid_q [NSTAGE];
    logic             cmsb_q;

    logic [WIDTH-1:0] src_a   [NSTAGE];
    logic [WIDTH-1:0] src_b   [NSTAGE];
    logic [WIDTH-1:0] src_sum [NSTAGE];
    logic             src_c   [NSTAGE];
    logic             src_v   [NSTAGE];
    logic             grp_cmsb[NSTAGE];

    logic [NSTAGE-1:0] adv;

    // Advance requests propagate backwards from the consumer so bubbles collapse.
    always_comb begin
        adv       = '0;
        adv[LAST] = !valid_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    assign in_ready = rst_n && adv[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int               LO       = k * GROUP;
        localparam int               GW       = group_width(WIDTH, GROUP, k);
        localparam int               HI       = LO + GW;
        localparam logic [WIDTH-1:0] REM_MASK = {WIDTH{1'b1}} << HI;

        logic [GW-1:0]    grp_sum;
        logic             grp_cout;
        logic [WIDTH-1:0] sum_d;

        if (k == 0) begin : g_head
            assign src_a[k]   = in_a;
            assign src_b[k]   = (in_mode == MODE_ADD) ? in_b : ~in_b;
            assign src_c[k]   = (in_mode == MODE_SUB);
            assign src_sum[k] = '0;
            assign src_v[k]   = in_valid;
        end else begin : g_body
            assign src_a[k]   = a_q[k-1];
            assign src_b[k]   = b_q[k-1];
            assign src_c[k]   = cout_q[k-1];
            assign src_sum[k] = sum_q[k-1];
            assign src_v[k]   = valid_q[k-1];
        end

        cla_group #(
            .GW (GW)
        ) u_group (
            .a     (src_a[k][LO +: GW]),
            .b     (src_b[k][LO +: GW]),
            .cin   (src_c[k]),
            .sum   (grp_sum),
            .cout  (grp_cout),
            .c_msb (grp_cmsb[k])
        );

        always_comb begin
            sum_d            = src_sum[k];
            sum_d[LO +: GW]  = grp_sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                cout_q[k]  <= 1'b0;
            end else if (adv[k]) begin
                valid_q[k] <= src_v[k];
                if (src_v[k]) begin
                    a_q[k]    <= src_a[k] & REM_MASK;
                    b_q[k]    <= src_b[k] & REM_MASK;
                    sum_q[k]  <= sum_d;
                    cout_q[k] <= grp_cout;
                end
            end
        end

        if (k == LAST) begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                end else if (adv[k] && src_v[k]) begin
                    cmsb_q <= grp_cmsb[k];
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign out_cout  = cout_q[LAST];
    assign out_ovf   = cmsb_q ^ cout_q[LAST];

`ifdef CLA_PIPE_SAT_EN
    logic [WIDTH-1:0] sat_val;

    // On overflow the wrapped sign is inverted, so a set MSB means the true result is positive.
    always_comb begin
        sat_val = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sat_val[i] = sum_q[LAST][WIDTH-1] ? sat_max_bit(i, WIDTH) : sat_min_bit(i, WIDTH);
        end
    end

    assign out_sum = out_ovf ? sat_val : sum_q[LAST];
`else
    assign out_sum = sum_q[LAST];
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
// ============================================================================
// Module : tb_cla_addsub_pipe
// Brief  : Directed self-checking bench for cla_addsub_pipe (WIDTH=15, GROUP=5).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_addsub_pipe;

`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_a;
    logic [14:0] in_b;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    cla_addsub_pipe #(
        .WIDTH (15),
        .GROUP (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    int          n_acc = 0;
    int          a0;
    logic [14:0] pin_s;
    logic        pin_c;
    logic        pin_o;
    bit          pin_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference from signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [14:0] a, input logic [14:0] b, input logic m);
        exp_t        e;
        int          sa, sb, r, ua, ub;
        logic [31:0] rw;
        ua  = int'(a);
        ub  = int'(b);
        sa  = ua - (a[14] ? 32768 : 0);
        sb  = ub - (b[14] ? 32768 : 0);
        r   = m ? (sa - sb) : (sa + sb);
        e.o = (r > 16383) || (r < -16384);
        e.c = m ? (ua >= ub) : ((ua + ub) >= 32768);
        rw  = r;
        e.s = rw[14:0];
        if (SAT && e.o) e.s = (r > 0) ? 15'h3FFF : 15'h4000;
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stray_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("out_sum", {17'd0, out_sum}, {17'd0, q[0].s});
                    chk("out_cout", {31'd0, out_cout}, {31'd0, q[0].c});
                    chk("out_ovf", {31'd0, out_ovf}, {31'd0, q[0].o});
                    if (out_ready) begin
                        if (q[0].lat) chk("latency", cyc - q[0].acc, 32'd3);
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                m_e = model(in_a, in_b, in_mode);
                chk("model_sum", {17'd0, m_e.s}, {17'd0, pin_s});
                chk("model_cout", {31'd0, m_e.c}, {31'd0, pin_c});
                chk("model_ovf", {31'd0, m_e.o}, {31'd0, pin_o});
                m_e.acc = cyc;
                m_e.lat = pin_lat;
                q.push_back(m_e);
                n_acc++;
            end
        end
    end

    task automatic send(input logic [14:0] a, input logic [14:0] b, input logic m,
                        input logic [14:0] es, input logic ec, input logic eo, input bit lat);
        int guard;
        bit done;
        guard    = 0;
        done     = 1'b0;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        pin_s    = es;
        pin_c    = ec;
        pin_o    = eo;
        pin_lat  = lat;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 40) begin
                    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        pin_s     = '0;
        pin_c     = 1'b0;
        pin_o     = 1'b0;
        pin_lat   = 1'b0;

        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_out_valid", {31'd0, out_valid}, 32'd0);
        chk("init_out_sum", {17'd0, out_sum}, 32'd0);
        chk("init_out_cout", {31'd0, out_cout}, 32'd0);
        chk("init_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("init_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        send(15'h0004, 15'h0002, 1'b0, 15'h0006, 1'b0, 1'b0, 1'b1);
        drain();

        send(15'h2000, 15'h2000, 1'b0, SAT ? 15'h3FFF : 15'h4000, 1'b0, 1'b1, 1'b1);
        send(15'h6000, 15'h6000, 1'b0, 15'h4000, 1'b1, 1'b0, 1'b1);
        send(15'h4000, 15'h4000, 1'b0, SAT ? 15'h4000 : 15'h0000, 1'b1, 1'b1, 1'b1);
        drain();

        send(15'h0004, 15'h7FFE, 1'b1, 15'h0006, 1'b0, 1'b0, 1'b1);
        send(15'h2000, 15'h6000, 1'b1, SAT ? 15'h3FFF : 15'h4000, 1'b0, 1'b1, 1'b1);
        send(15'h4000, 15'h3FFF, 1'b1, SAT ? 15'h4000 : 15'h0001, 1'b1, 1'b1, 1'b1);
        drain();

        out_ready = 1'b0;
        a0        = n_acc;
        fork
            begin
                send(15'h0011, 15'h0022, 1'b0, 15'h0033, 1'b0, 1'b0, 1'b0);
                send(15'h7FFF, 15'h0001, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0);
                send(15'h3FFF, 15'h0001, 1'b0, SAT ? 15'h3FFF : 15'h4000, 1'b0, 1'b1, 1'b0);
                send(15'h1234, 15'h0FFF, 1'b0, 15'h2233, 1'b0, 1'b0, 1'b0);
                send(15'h5555, 15'h2AAA, 1'b0, 15'h7FFF, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepts", n_acc - a0, 32'd3);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(15'h0100, 15'h0200, 1'b0, 15'h0300, 1'b0, 1'b0, 1'b0);
        send(15'h0001, 15'h0001, 1'b0, 15'h0002, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_sum", {17'd0, out_sum}, 32'd0);
        chk("mid_rst_out_cout", {31'd0, out_cout}, 32'd0);
        chk("mid_rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(15'h1111, 15'h0111, 1'b1, 15'h1000, 1'b1, 1'b0, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
